// File: rtl/sudoku_puzzle_loader.sv
// Feeds an 81-digit puzzle stream into the solver's board-entry port using
// Enter/Next pulses, checks the solver cursor after each step, then issues Start.
module sudoku_puzzle_loader #(
    parameter int WAIT_MAX = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Go_i,
    input  logic       DigitValid_i,
    input  logic [3:0] Digit_i,
    output logic       DigitReady_o,
    input  logic       SolLoad_i,
    input  logic [3:0] SolRow_i,
    input  logic [3:0] SolCol_i,
    output logic [3:0] SolValue_o,
    output logic       SolEnter_o,
    output logic       SolNext_o,
    output logic       SolPrev_o,
    output logic       SolStart_o,
    output logic       Busy_o,
    output logic       Done_o,
    output logic       Err_o,
    output logic [1:0] ErrCode_o,
    output logic [6:0] CellCount_o
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WAIT_LOAD = 4'd1;
    localparam logic [3:0] S_FETCH     = 4'd2;
    localparam logic [3:0] S_ENTER     = 4'd3;
    localparam logic [3:0] S_ADVANCE   = 4'd4;
    localparam logic [3:0] S_SYNC      = 4'd5;
    localparam logic [3:0] S_START     = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    localparam logic [1:0] E_LOAD_LOST = 2'b00;
    localparam logic [1:0] E_TIMEOUT   = 2'b01;
    localparam logic [1:0] E_POSITION  = 2'b10;
    localparam logic [1:0] E_DIGIT     = 2'b11;

    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    logic [3:0]    state_q, state_d;
    logic [3:0]    exp_row_q, exp_row_d;
    logic [3:0]    exp_col_q, exp_col_d;
    logic [3:0]    digit_q, digit_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [6:0]    count_q, count_d;
    logic [1:0]    code_q, code_d;

    logic last_cell;
    assign last_cell = (exp_row_q == 4'd8) && (exp_col_q == 4'd8);

    always_comb begin
        state_d   = state_q;
        exp_row_d = exp_row_q;
        exp_col_d = exp_col_q;
        digit_d   = digit_q;
        wait_d    = wait_q;
        count_d   = count_q;
        code_d    = code_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Go_i) begin
                    count_d   = 7'd0;
                    exp_row_d = 4'd0;
                    exp_col_d = 4'd0;
                    wait_d    = '0;
                    code_d    = E_LOAD_LOST;
                    state_d   = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                if (SolLoad_i) begin
                    if (SolRow_i == 4'd0 && SolCol_i == 4'd0) begin
                        state_d = S_FETCH;
                    end else begin
                        code_d  = E_POSITION;
                        state_d = S_ERR;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    code_d  = E_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_FETCH: begin
                // Losing SolLoad outranks every other transition of the load loop.
                if (!SolLoad_i) begin
                    code_d  = E_LOAD_LOST;
                    state_d = S_ERR;
                end else if (DigitValid_i) begin
                    if (Digit_i > 4'd9) begin
                        code_d  = E_DIGIT;
                        state_d = S_ERR;
                    end else begin
                        digit_d = Digit_i;
                        state_d = S_ENTER;
                    end
                end
            end
            S_ENTER: begin
                if (!SolLoad_i) begin
                    code_d  = E_LOAD_LOST;
                    state_d = S_ERR;
                end else begin
                    count_d = count_q + 7'd1;
                    state_d = last_cell ? S_START : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (!SolLoad_i) begin
                    code_d  = E_LOAD_LOST;
                    state_d = S_ERR;
                end else begin
                    if (exp_col_q == 4'd8) begin
                        exp_col_d = 4'd0;
                        exp_row_d = exp_row_q + 4'd1;
                    end else begin
                        exp_col_d = exp_col_q + 4'd1;
                    end
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // The solver cursor has already moved on the SolNext edge.
                if (!SolLoad_i) begin
                    code_d  = E_LOAD_LOST;
                    state_d = S_ERR;
                end else if (SolRow_i == exp_row_q && SolCol_i == exp_col_q) begin
                    state_d = S_FETCH;
                end else begin
                    code_d  = E_POSITION;
                    state_d = S_ERR;
                end
            end
            S_START: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            exp_row_q <= 4'd0;
            exp_col_q <= 4'd0;
            digit_q   <= 4'd0;
            wait_q    <= '0;
            count_q   <= 7'd0;
            code_q    <= E_LOAD_LOST;
        end else begin
            state_q   <= state_d;
            exp_row_q <= exp_row_d;
            exp_col_q <= exp_col_d;
            digit_q   <= digit_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            code_q    <= code_d;
        end
    end

    assign DigitReady_o = (state_q == S_FETCH);
    assign SolEnter_o   = (state_q == S_ENTER);
    assign SolNext_o    = (state_q == S_ADVANCE);
    assign SolStart_o   = (state_q == S_START);
    assign SolPrev_o    = 1'b0;
    assign SolValue_o   = digit_q;
    assign Busy_o       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign Done_o       = (state_q == S_DONE);
    assign Err_o        = (state_q == S_ERR);
    assign ErrCode_o    = code_q;
    assign CellCount_o  = count_q;

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Randomized bench for sudoku_puzzle_loader: a cycle schedule is derived from the
// stream/valid pattern and every output is compared against it, with a solver model.
module tb_sudoku_puzzle_loader;

    localparam int MAXC     = 1200;
    localparam int WAIT_MAX = 255;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Go;
    logic       DigitValid;
    logic [3:0] Digit;
    logic       DigitReady;
    logic       SolLoad;
    logic [3:0] SolRow;
    logic [3:0] SolCol;
    logic [3:0] SolValue;
    logic       SolEnter, SolNext, SolPrev, SolStart;
    logic       Busy, Done, Err;
    logic [1:0] ErrCode;
    logic [6:0] CellCount;

    sudoku_puzzle_loader #(.WAIT_MAX(WAIT_MAX)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Go_i         (Go),
        .DigitValid_i (DigitValid),
        .Digit_i      (Digit),
        .DigitReady_o (DigitReady),
        .SolLoad_i    (SolLoad),
        .SolRow_i     (SolRow),
        .SolCol_i     (SolCol),
        .SolValue_o   (SolValue),
        .SolEnter_o   (SolEnter),
        .SolNext_o    (SolNext),
        .SolPrev_o    (SolPrev),
        .SolStart_o   (SolStart),
        .Busy_o       (Busy),
        .Done_o       (Done),
        .Err_o        (Err),
        .ErrCode_o    (ErrCode),
        .CellCount_o  (CellCount)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected per-cycle behaviour of one run; cycle 0 is the cycle Go is driven.
    bit e_ready[MAXC], e_enter[MAXC], e_next[MAXC], e_start[MAXC];
    bit e_busy[MAXC], e_done[MAXC], e_err[MAXC];
    int e_count[MAXC], e_val[MAXC];
    int e_code, end_cyc, drop_cyc;
    bit valid_pat[MAXC];
    int stream[81];
    int board[81];
    int done_seen, err_seen, n_ent, n_nxt, n_st;

    task automatic chk(input string name, input int c, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    // Timeline from the rules: each cell waits in FETCH for valid, then ENTER,
    // ADVANCE, SYNC; the last cell replaces ADVANCE/SYNC with START.
    task automatic build_schedule(input int mode, input int k);
        int t, fin;
        bit is_done;
        for (int c = 0; c < MAXC; c++) begin
            e_ready[c] = 0; e_enter[c] = 0; e_next[c] = 0; e_start[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_count[c] = 0; e_val[c] = 0;
        end
        drop_cyc = MAXC;
        e_code = 0;
        fin = 0;
        is_done = 0;
        end_cyc = 2;
        if (mode == 4) begin
            end_cyc = 1 + WAIT_MAX;
            e_code = 1;
        end else if (mode == 5) begin
            end_cyc = 2;
            e_code = 2;
        end else begin
            t = 2;
            for (int i = 0; i < 81; i++) begin
                if (mode == 3 && i == k) begin
                    e_ready[t] = 1; e_count[t] = i;
                    drop_cyc = t; end_cyc = t + 1; fin = i; e_code = 0;
                    break;
                end
                while (!valid_pat[t] && t < MAXC - 10) begin
                    e_ready[t] = 1; e_count[t] = i; t++;
                end
                e_ready[t] = 1; e_count[t] = i;
                if (mode == 1 && i == k) begin
                    end_cyc = t + 1; fin = i; e_code = 3;
                    break;
                end
                e_enter[t + 1] = 1; e_count[t + 1] = i; e_val[t + 1] = stream[i];
                if (i == 80) begin
                    e_start[t + 2] = 1; e_count[t + 2] = 81;
                    end_cyc = t + 3; fin = 81; is_done = 1;
                    break;
                end
                e_next[t + 2] = 1; e_count[t + 2] = i + 1; e_count[t + 3] = i + 1;
                if (mode == 2 && i == k) begin
                    end_cyc = t + 4; fin = i + 1; e_code = 2;
                    break;
                end
                t = t + 4;
            end
        end
        for (int c = 1; c < end_cyc; c++) e_busy[c] = 1;
        for (int c = end_cyc; c < MAXC; c++) begin
            e_done[c] = is_done; e_err[c] = !is_done; e_count[c] = fin;
        end
    endtask

    task automatic do_run(input int mode, input int k, input int reset_cell);
        int row, col, ents, src, run_len, reset_at, seen;
        build_schedule(mode, k);
        row = 0; col = (mode == 5) ? 3 : 0; ents = 0; src = 0;
        done_seen = -1; err_seen = -1; n_ent = 0; n_nxt = 0; n_st = 0;
        for (int i = 0; i < 81; i++) board[i] = -1;
        reset_at = -1;
        seen = 0;
        if (reset_cell >= 0) begin
            for (int c = 0; c < MAXC; c++) begin
                if (e_enter[c]) begin
                    if (seen == reset_cell) begin reset_at = c; break; end
                    seen++;
                end
            end
        end
        run_len = end_cyc + 8;
        for (int c = 0; c < run_len; c++) begin
            if (c == reset_at) begin
                @(posedge Clk); #1;
                chk("enter_before_reset", c, int'(SolEnter), 1);
                Reset = 1'b1;
                #1;
                chk("enter_drop_on_reset", c, int'(SolEnter), 0);
                chk("busy_on_reset", c, int'(Busy), 0);
                chk("count_on_reset", c, int'(CellCount), 0);
                chk("value_on_reset", c, int'(SolValue), 0);
                @(negedge Clk);
                Reset = 1'b0;
                break;
            end
            @(negedge Clk);
            if (c >= 1) begin
                chk("ready", c, int'(DigitReady), int'(e_ready[c]));
                chk("enter", c, int'(SolEnter), int'(e_enter[c]));
                chk("next", c, int'(SolNext), int'(e_next[c]));
                chk("start", c, int'(SolStart), int'(e_start[c]));
                chk("prev", c, int'(SolPrev), 0);
                chk("busy", c, int'(Busy), int'(e_busy[c]));
                chk("done", c, int'(Done), int'(e_done[c]));
                chk("err", c, int'(Err), int'(e_err[c]));
                chk("cellcount", c, int'(CellCount), e_count[c]);
                if (e_err[c]) chk("errcode", c, int'(ErrCode), e_code);
                if (e_enter[c]) chk("value", c, int'(SolValue), e_val[c]);
                if (SolEnter) n_ent++;
                if (SolNext) n_nxt++;
                if (SolStart) n_st++;
                if (Done && done_seen < 0) done_seen = c;
                if (Err && err_seen < 0) err_seen = c;
            end
            // Solver model: writes on Enter, steps cursor on Next unless told to skip.
            if (SolEnter) begin
                if (row < 9 && col < 9) board[row * 9 + col] = int'(SolValue);
                ents++;
            end
            if (SolNext && !(mode == 2 && ents == k + 1)) begin
                if (col == 8) begin col = 0; row++; end
                else col++;
            end
            Go = (c == 0);
            DigitValid = valid_pat[c];
            Digit = (src < 81) ? 4'(stream[src]) : 4'd0;
            SolLoad = (mode != 4) && (c < drop_cyc);
            SolRow = 4'(row);
            SolCol = 4'(col);
            if (DigitReady && DigitValid) src++;
        end
        Go = 1'b0;
        DigitValid = 1'b0;
    endtask

    task automatic check_board(input string name);
        for (int i = 0; i < 81; i++) chk(name, i, board[i], stream[i]);
    endtask

    initial begin
        Reset = 1'b1; Go = 1'b0; DigitValid = 1'b0; Digit = 4'd0;
        SolLoad = 1'b0; SolRow = 4'd0; SolCol = 4'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", 0, int'(DigitReady), 0);
        chk("rst_enter", 0, int'(SolEnter), 0);
        chk("rst_next", 0, int'(SolNext), 0);
        chk("rst_start", 0, int'(SolStart), 0);
        chk("rst_prev", 0, int'(SolPrev), 0);
        chk("rst_busy", 0, int'(Busy), 0);
        chk("rst_done", 0, int'(Done), 0);
        chk("rst_err", 0, int'(Err), 0);
        chk("rst_errcode", 0, int'(ErrCode), 0);
        chk("rst_count", 0, int'(CellCount), 0);
        chk("rst_value", 0, int'(SolValue), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Full load, fixed pattern, valid always high.
        for (int i = 0; i < 81; i++) stream[i] = (i % 3 == 2) ? 0 : (i % 9) + 1;
        for (int c = 0; c < MAXC; c++) valid_pat[c] = 1'b1;
        do_run(0, 0, -1);
        chk("A_done_cycle", 0, done_seen, 325);
        chk("A_enters", 0, n_ent, 81);
        chk("A_nexts", 0, n_nxt, 80);
        chk("A_starts", 0, n_st, 1);
        chk("A_count", 0, int'(CellCount), 81);
        check_board("A_board");

        // Same stream with DigitValid toggling.
        for (int c = 0; c < MAXC; c++) valid_pat[c] = ((c % 2) != ((c / 7) % 2));
        do_run(0, 0, -1);
        chk("B_enters", 0, n_ent, 81);
        chk("B_nexts", 0, n_nxt, 80);
        chk("B_starts", 0, n_st, 1);
        check_board("B_board");

        // Illegal digit at cell 40, random stream and random valid.
        for (int i = 0; i < 81; i++) stream[i] = $urandom_range(0, 9);
        stream[40] = 12;
        for (int c = 0; c < MAXC; c++) valid_pat[c] = ($urandom_range(0, 3) != 0);
        do_run(1, 40, -1);
        chk("C_count", 0, int'(CellCount), 40);
        chk("C_code", 0, int'(ErrCode), 3);
        chk("C_enters", 0, n_ent, 40);

        // Solver misses its cursor step after cell 9's Next.
        for (int i = 0; i < 81; i++) stream[i] = $urandom_range(0, 9);
        for (int c = 0; c < MAXC; c++) valid_pat[c] = 1'b1;
        do_run(2, 9, -1);
        chk("D_code", 0, int'(ErrCode), 2);
        chk("D_err_cycle", 0, err_seen, 2 + 9 * 4 + 4);

        // SolLoad never rises.
        do_run(4, 0, -1);
        chk("E_err_cycle", 0, err_seen, 256);
        chk("E_code", 0, int'(ErrCode), 1);

        // SolLoad drops at cell 20.
        for (int c = 0; c < MAXC; c++) valid_pat[c] = ($urandom_range(0, 2) != 0);
        do_run(3, 20, -1);
        chk("F_code", 0, int'(ErrCode), 0);
        chk("F_count", 0, int'(CellCount), 20);

        // Solver reports LOAD away from (0,0).
        do_run(5, 0, -1);
        chk("G_code", 0, int'(ErrCode), 2);

        // Reset during the Enter of cell 5, then a clean reload.
        for (int c = 0; c < MAXC; c++) valid_pat[c] = 1'b1;
        do_run(0, 0, 5);
        do_run(0, 0, -1);
        chk("I_done_cycle", 0, done_seen, 325);
        chk("I_enters", 0, n_ent, 81);
        check_board("I_board");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
